// File: rtl/inst_mem_ctrl.sv
// Loadable instruction RAM on the core's fetch port: a loader fills it while the
// core is stalled, then it serves one-cycle-latency fetches with fault flags.
module inst_mem_ctrl #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              oob_o,
  input  logic              ld_start_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_done_i,
  output logic [ADDR_W:0]   ld_count_o
);

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [29:0]     DEPTH_WORDS = 30'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_MAX   = (ADDR_W + 1)'(DEPTH);

  state_t state;
  state_t state_nxt;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data;
  logic              rd_sel;
  logic              fetch;
  logic              aligned;
  logic              in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // A new load request overrides a simultaneous done pulse.
  always_comb begin
    state_nxt = state;
    if (ld_start_i)                        state_nxt = LOAD;
    else if (state == LOAD && ld_done_i)   state_nxt = RUN;
  end

  always_comb begin
    stall_o = (state == LOAD);
  end

  always_comb begin
    fetch    = (state == RUN) && ce_i;
    aligned  = (addr_i[1:0] == 2'b00);
    in_range = (addr_i[31:2] < DEPTH_WORDS);
    rd_idx   = addr_i[ADDR_W+1:2];
    wr_en    = (state == LOAD) && ld_we_i && ({1'b0, ld_addr_i} < COUNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_addr_i] <= ld_data_i;
  end

  // Read data register has no reset so it maps onto block RAM; rd_sel masks it
  // to NOP_WORD whenever the previous fetch was absent, faulty or reset away.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sel       <= 1'b0;
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      oob_o        <= 1'b0;
    end else begin
      rd_sel       <= fetch && aligned && in_range;
      inst_valid_o <= fetch;
      misalign_o   <= fetch && !aligned;
      oob_o        <= fetch && aligned && !in_range;
    end
  end

  always_comb begin
    inst_o = rd_sel ? rd_data : NOP_WORD;
  end

  always_ff @(posedge clk) begin
    if (rst || ld_start_i)
      ld_count_o <= '0;
    else if (state == LOAD && ld_we_i && ld_count_o != COUNT_MAX)
      ld_count_o <= ld_count_o + 1'b1;
  end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: directed scenarios plus randomized traffic checked
// against a word-array / mode-flag reference model.
module tb_inst_mem_ctrl;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic              ce;
  logic [31:0]       addr;
  logic [31:0]       inst_o;
  logic              inst_valid_o;
  logic              stall_o;
  logic              misalign_o;
  logic              oob_o;
  logic              ld_start;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count_o;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [31:0] m_mem [DEPTH];
  bit          m_run   = 0;
  int          m_count = 0;
  logic [31:0] exp_inst;
  logic        exp_valid, exp_mis, exp_oob;

  inst_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .oob_o(oob_o), .ld_start_i(ld_start), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .ld_done_i(ld_done), .ld_count_o(ld_count_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Advance one clock: update the model from the current inputs, then let the
  // edge happen, then drop all pulse inputs.
  task automatic tick();
    logic [31:0] ni;
    logic nv, nm, no;
    ni = NOP; nv = 0; nm = 0; no = 0;
    if (!rst && m_run && ce) begin
      nv = 1;
      nm = (addr % 4) != 0;
      no = !nm && (addr / 4) >= DEPTH;
      if (!nm && !no) ni = m_mem[addr / 4];
    end
    if (rst) begin
      m_run = 0; m_count = 0;
    end else begin
      if (!m_run && ld_we) begin
        m_mem[ld_addr] = ld_data;
        m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
      end
      if (ld_start) begin m_run = 0; m_count = 0; end
      else if (ld_done) m_run = 1;
    end
    @(posedge clk); #1;
    exp_inst = ni; exp_valid = nv; exp_mis = nm; exp_oob = no;
    rst = 0; ce = 0; ld_start = 0; ld_we = 0; ld_done = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick();
    checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", inst_o, NOP); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
    checks++; if (misalign_o !== 1'b0 || oob_o !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", misalign_o, oob_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", stall_o); end
    checks++; if (ld_count_o !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ld_count_o); end
  endtask

  task automatic test_load();
    ld_we = 1; ld_addr = 0; ld_data = 32'h3401_1100; tick();
    checks++; if (ld_count_o !== 11'd1) begin errors++; $display("FAIL load_count1 got=%0d exp=1", ld_count_o); end
    ld_we = 1; ld_addr = 1; ld_data = 32'h3402_0020; tick();
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL load_stall got=%b exp=1", stall_o); end
    ld_done = 1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL load_stall_pre_done got=%b exp=1", stall_o); end
    tick();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL load_stall_after_done got=%b exp=0", stall_o); end
    checks++; if (ld_count_o !== 11'd2) begin errors++; $display("FAIL load_count2 got=%0d exp=2", ld_count_o); end
  endtask

  task automatic test_pipelined();
    logic [31:0] a   [3] = '{32'h0, 32'h4, 32'h0};
    logic [31:0] exp [3] = '{32'h3401_1100, 32'h3402_0020, 32'h3401_1100};
    for (int i = 0; i < 3; i++) begin
      ce = 1; addr = a[i]; tick();
      checks++; if (inst_o !== exp[i]) begin errors++; $display("FAIL pipe_inst%0d got=%h exp=%h", i, inst_o, exp[i]); end
      checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL pipe_valid%0d got=%b exp=1", i, inst_valid_o); end
    end
  endtask

  task automatic test_flags();
    logic [31:0] a [3] = '{32'h2, 32'h1000, 32'h1002};
    logic        em[3] = '{1'b1, 1'b0, 1'b1};
    logic        eo[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      ce = 1; addr = a[i]; tick();
      checks++; if (misalign_o !== em[i] || oob_o !== eo[i]) begin errors++; $display("FAIL flags%0d got mis=%b oob=%b exp mis=%b oob=%b", i, misalign_o, oob_o, em[i], eo[i]); end
      checks++; if (inst_o !== NOP || inst_valid_o !== 1'b1) begin errors++; $display("FAIL flags_inst%0d got=%h/%b exp=%h/1", i, inst_o, inst_valid_o, NOP); end
    end
  endtask

  task automatic test_ce_idle();
    ce = 0; addr = 32'h4; tick();
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL idle got=%h/%b exp=%h/0", inst_o, inst_valid_o, NOP); end
  endtask

  task automatic test_reload();
    ld_start = 1; tick();
    checks++; if (stall_o !== 1'b1 || ld_count_o !== '0) begin errors++; $display("FAIL reload_enter got stall=%b cnt=%0d exp stall=1 cnt=0", stall_o, ld_count_o); end
    ce = 1; addr = 32'h0; tick();
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL load_fetch got=%h/%b exp=%h/0", inst_o, inst_valid_o, NOP); end
    ld_we = 1; ld_addr = 1; ld_data = 32'hFFFF_FFFF; tick();
    ld_done = 1; tick();
    ce = 1; addr = 32'h4; tick();
    checks++; if (inst_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reload_inst got=%h exp=ffffffff", inst_o); end
    ld_start = 1; ld_done = 1; tick();
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL start_done_prio got stall=%b exp=1", stall_o); end
    ld_done = 1; tick();
    ld_we = 1; ld_addr = 1; ld_data = 32'h1234_5678; tick();
    checks++; if (ld_count_o !== '0) begin errors++; $display("FAIL run_we_count got=%0d exp=0", ld_count_o); end
    ce = 1; addr = 32'h4; tick();
    checks++; if (inst_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL run_we_nowrite got=%h exp=ffffffff", inst_o); end
  endtask

  task automatic test_done_cycle();
    ld_start = 1; tick();
    ld_done = 1; ce = 1; addr = 32'h0; tick();
    checks++; if (inst_valid_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL done_cycle got valid=%b stall=%b exp valid=0 stall=0", inst_valid_o, stall_o); end
    ce = 1; addr = 32'h0; tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h3401_1100) begin errors++; $display("FAIL first_run_fetch got=%h/%b exp=34011100/1", inst_o, inst_valid_o); end
  endtask

  task automatic test_saturate();
    ld_start = 1; tick();
    for (int i = 0; i < DEPTH + 6; i++) begin
      ld_we = 1; ld_addr = ADDR_W'(i % DEPTH);
      ld_data = (i % DEPTH == 0) ? 32'h3401_1100 : $urandom;
      tick();
      if (i == DEPTH - 1) begin
        checks++; if (ld_count_o !== 11'(DEPTH)) begin errors++; $display("FAIL count_full got=%0d exp=%0d", ld_count_o, DEPTH); end
      end
    end
    checks++; if (ld_count_o !== 11'(DEPTH)) begin errors++; $display("FAIL count_sat got=%0d exp=%0d", ld_count_o, DEPTH); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sat_still_load got stall=%b exp=1", stall_o); end
    ld_done = 1; tick();
  endtask

  task automatic test_reset_mid();
    ce = 1; addr = 32'h4; rst = 1; tick();
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL rst_mid_fetch got=%h/%b exp=%h/0", inst_o, inst_valid_o, NOP); end
    checks++; if (stall_o !== 1'b1 || ld_count_o !== '0) begin errors++; $display("FAIL rst_mid_state got stall=%b cnt=%0d exp 1/0", stall_o, ld_count_o); end
    ld_done = 1; tick();
    ce = 1; addr = 32'h0; tick();
    checks++; if (inst_o !== 32'h3401_1100 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL ram_retained got=%h/%b exp=34011100/1", inst_o, inst_valid_o); end
  endtask

  task automatic test_random();
    int r, k;
    for (int i = 0; i < 800; i++) begin
      r        = $urandom_range(0, 99);
      rst      = (r == 0);
      ld_start = (r >= 1 && r <= 3);
      ld_done  = (r >= 4 && r <= 12);
      ce       = $urandom_range(0, 1);
      k        = $urandom_range(0, 9);
      if (k < 6)      addr = 32'($urandom_range(0, 15)) << 2;
      else if (k < 8) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else begin addr = $urandom; addr[12] = 1'b1; end
      ld_we    = !rst && !ld_start && ($urandom_range(0, 1) == 1);
      ld_addr  = ADDR_W'($urandom_range(0, 15));
      ld_data  = $urandom;
      tick();
      checks++; if (inst_o !== exp_inst) begin errors++; $display("FAIL rnd_inst i=%0d got=%h exp=%h", i, inst_o, exp_inst); end
      checks++; if (inst_valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, inst_valid_o, exp_valid); end
      checks++; if (misalign_o !== exp_mis || oob_o !== exp_oob) begin errors++; $display("FAIL rnd_flags i=%0d got=%b%b exp=%b%b", i, misalign_o, oob_o, exp_mis, exp_oob); end
      checks++; if (stall_o !== !m_run) begin errors++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall_o, !m_run); end
      checks++; if (ld_count_o !== 11'(m_count)) begin errors++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, ld_count_o, m_count); end
    end
  endtask

  initial begin
    rst = 0; ce = 0; addr = '0; ld_start = 0; ld_we = 0; ld_addr = '0;
    ld_data = '0; ld_done = 0;
    #2;
    test_reset();
    test_load();
    test_pipelined();
    test_flags();
    test_ce_idle();
    test_reload();
    test_done_cycle();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
Responder end of the core's instruction-fetch interface (ce / addr -> inst).
- Replaces the combinational instruction ROM with a loadable, synchronous-read instruction RAM.
- An external loader fills it after reset; the core is held stalled until loading completes.
- Sits between the CPU core and the program loader in cpu_top.

Parameters:
DEPTH, 1024, number of 32-bit instruction words
ADDR_W, 10, log2(DEPTH); word-index width
NOP_WORD, 32'h00000000, instruction returned when no valid word is available

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
ce_i  input  1  fetch enable from core (rom_ce)
addr_i  input  32  byte address from core (rom_addr)
inst_o  output  32  fetched instruction (rom_data)
inst_valid_o  output  1  inst_o corresponds to the fetch issued the previous cycle
stall_o  output  1  core must hold its PC; high while not in RUN
misalign_o  output  1  previous fetch address had addr[1:0] != 0
oob_o  output  1  previous fetch word index >= DEPTH
ld_start_i  input  1  pulse: enter LOAD, reset the load counter
ld_we_i  input  1  write one program word
ld_addr_i  input  ADDR_W  word index to write
ld_data_i  input  32  word to write
ld_done_i  input  1  pulse: loading finished
ld_count_o  output  ADDR_W+1  words written since the last LOAD entry, saturating at DEPTH

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = LOAD
  - inst_o = NOP_WORD
  - inst_valid_o = 0, misalign_o = 0, oob_o = 0
  - stall_o = 1
  - ld_count_o = 0
  - RAM contents are not cleared.
- FSM states: LOAD, RUN.
  - LOAD -> RUN: on ld_done_i.
  - RUN -> LOAD: on ld_start_i.
  - ld_start_i and ld_done_i together: ld_start_i wins; state is LOAD.
  - ld_start_i while already in LOAD: counter clears, state stays LOAD.
- stall_o is combinational from state: 1 in LOAD, 0 in RUN.
- LOAD state:
  - ld_we_i writes mem[ld_addr_i] <= ld_data_i at the clock edge.
  - Each write increments ld_count_o, saturating at DEPTH.
  - Rewriting the same index still counts.
  - Fetches are ignored: next-cycle inst_o = NOP_WORD, inst_valid_o = 0, flags = 0.
- RUN state:
  - ld_we_i is ignored; there are no writes and ld_count_o holds.
- Fetch path in RUN, read latency exactly 1 cycle:
  - Word index = addr_i[ADDR_W+1:2]. Out-of-range means addr_i[31:ADDR_W+2] != 0.
  - ce_i = 1, aligned, in range: next cycle inst_o = mem[index], inst_valid_o = 1, misalign_o = 0, oob_o = 0.
  - ce_i = 1, misaligned: next cycle inst_o = NOP_WORD, inst_valid_o = 1, misalign_o = 1. Misaligned has priority over oob_o.
  - ce_i = 1, aligned, out of range: next cycle inst_o = NOP_WORD, inst_valid_o = 1, oob_o = 1.
  - ce_i = 0: next cycle inst_o = NOP_WORD, inst_valid_o = 0, flags = 0.
- Back-to-back fetches are fully pipelined: one result per cycle, no bubbles.
- Same-cycle write and read cannot collide: writes happen only in LOAD, reads only in RUN.
- Transition cycle: the first fetch accepted is the one presented in the first cycle where state == RUN. The ld_done_i cycle itself still counts as LOAD for fetch purposes.
- rst asserted mid-load or mid-run:
  - Registers return to their reset values at that edge.
  - An in-flight fetch result is discarded.
  - RAM words already written are retained.
- Loading is complete only after ld_done_i; ld_count_o reaching DEPTH does not end LOAD.

Test Plan:
1. Reset then load: rst 1 cycle; write mem[0]=32'h3401_1100, mem[1]=32'h3402_0020; pulse ld_done_i -> stall_o 1 until the ld_done_i edge then 0; ld_count_o = 2.
2. Pipelined fetch: in RUN, ce_i=1 with addr 0x0, 0x4, 0x0 on consecutive cycles -> inst_o = 32'h34011100, 32'h34020020, 32'h34011100 one cycle later each; inst_valid_o = 1 for 3 cycles.
3. Fault flags: addr 0x2 -> misalign_o = 1, inst_o = 0. Addr 0x1000 (DEPTH 1024) -> oob_o = 1, inst_o = 0. Addr 0x1002 -> misalign_o = 1, oob_o = 0.
4. Fetch during load and ce_i=0: ce_i=1 in LOAD -> inst_valid_o = 0, inst_o = 0. In RUN, ce_i=0 -> inst_valid_o = 0, inst_o = 0.
5. Reload and priority:
   - In RUN, pulse ld_start_i -> LOAD, ld_count_o = 0.
   - Overwrite mem[1] = 32'hFFFF_FFFF, pulse ld_done_i, fetch 0x4 -> inst_o = 32'hFFFFFFFF.
   - ld_start_i and ld_done_i in the same cycle -> state LOAD.
   - ld_we_i in RUN -> no write, ld_count_o unchanged.
6. Reset mid-operation: rst during a RUN fetch of 0x4 -> next cycle inst_valid_o = 0, stall_o = 1, ld_count_o = 0. Then ld_done_i and a fetch of 0x0 -> 32'h34011100, showing RAM is retained.
